dds_sweep_controller: RTL

Sequencer that drives the tuning-word and amplitude inputs of the DDS generator to produce an enveloped frequency sweep (chirp).
- Each burst runs: amplitude ramp-up, stepped frequency sweep from a start word to a stop word, then amplitude ramp-down.
- Step dwell is counted in DDS output periods, using the DDS overflow pulse.
- Sits between the control/register logic and the DDS instance.

---
 rtl/dds_sweep_controller.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dds_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module   : dds_sweep_controller
// Purpose  : Chirp sequencer feeding a DDS: amplitude ramp-up, stepped
//            tuning-word sweep paced by DDS overflow pulses, amplitude ramp-down.
// Revision : 1.0 - initial release
// ============================================================================
module dds_sweep_controller #(
  parameter int TW_WIDTH    = 8,
  parameter int AMP_WIDTH   = 8,
  parameter int DWELL_WIDTH = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start_i,
  input  logic                   Abort_i,
  input  logic [TW_WIDTH-1:0]    StartWord_i,
  input  logic [TW_WIDTH-1:0]    StopWord_i,
  input  logic [TW_WIDTH-1:0]    StepWord_i,
  input  logic [DWELL_WIDTH-1:0] Dwell_i,
  input  logic [AMP_WIDTH-1:0]   RampStep_i,
  input  logic                   Overflow_i,
  output logic [TW_WIDTH-1:0]    TuningWord_o,
  output logic [AMP_WIDTH-1:0]   Amplitude_o,
  output logic                   Busy_o,
  output logic                   Done_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    SWEEP     = 3'd2,
    RAMP_DOWN = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [AMP_WIDTH-1:0]   AMP_FULL  = '1;
  localparam logic [AMP_WIDTH-1:0]   AMP_ZERO  = '0;
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);
  localparam logic [DWELL_WIDTH:0]   CNT_ONE   = (DWELL_WIDTH+1)'(1);

  state_t                 state_q, state_d;
  logic [TW_WIDTH-1:0]    tw_q, tw_d;
  logic [TW_WIDTH-1:0]    stop_q, stop_d;
  logic [TW_WIDTH-1:0]    step_q, step_d;
  logic                   up_q, up_d;
  logic [AMP_WIDTH-1:0]   amp_q, amp_d;
  logic [AMP_WIDTH-1:0]   ramp_q, ramp_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [AMP_WIDTH:0]     amp_sum;
  logic [AMP_WIDTH-1:0]   amp_inc;
  logic [AMP_WIDTH-1:0]   amp_dec;
  logic [DWELL_WIDTH-1:0] dwell_eff;
  logic [DWELL_WIDTH:0]   cnt_inc;
  logic                   dwell_hit;
  logic [TW_WIDTH:0]      tw_gap;
  logic [TW_WIDTH-1:0]    tw_step;

  // Saturating ramp arithmetic and a clamped step that can never pass the stop word.
  always_comb begin
    amp_sum = {1'b0, amp_q} + {1'b0, ramp_q};
    if (ramp_q == AMP_ZERO || amp_sum[AMP_WIDTH]) begin
      amp_inc = AMP_FULL;
    end else begin
      amp_inc = amp_sum[AMP_WIDTH-1:0];
    end
    if (ramp_q == AMP_ZERO || ramp_q >= amp_q) begin
      amp_dec = AMP_ZERO;
    end else begin
      amp_dec = amp_q - ramp_q;
    end
    dwell_eff = (dwell_q == '0) ? DWELL_ONE : dwell_q;
    cnt_inc   = {1'b0, cnt_q} + CNT_ONE;
    dwell_hit = (cnt_inc >= {1'b0, dwell_eff});
    tw_gap    = up_q ? ({1'b0, stop_q} - {1'b0, tw_q})
                     : ({1'b0, tw_q} - {1'b0, stop_q});
    if ({1'b0, step_q} >= tw_gap) begin
      tw_step = stop_q;
    end else if (up_q) begin
      tw_step = tw_q + step_q;
    end else begin
      tw_step = tw_q - step_q;
    end
  end

  always_comb begin
    state_d = state_q;
    tw_d    = tw_q;
    stop_d  = stop_q;
    step_d  = step_q;
    up_d    = up_q;
    amp_d   = amp_q;
    ramp_d  = ramp_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        amp_d = AMP_ZERO;
        if (Start_i) begin
          tw_d    = StartWord_i;
          stop_d  = StopWord_i;
          step_d  = StepWord_i;
          up_d    = (StopWord_i >= StartWord_i);
          ramp_d  = RampStep_i;
          dwell_d = Dwell_i;
          cnt_d   = '0;
          state_d = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (Abort_i) begin
          state_d = RAMP_DOWN;
        end else begin
          amp_d = amp_inc;
          if (amp_inc == AMP_FULL) begin
            cnt_d   = '0;
            state_d = SWEEP;
          end
        end
      end
      SWEEP: begin
        // Abort takes priority over a dwell completing in the same cycle.
        if (Abort_i) begin
          state_d = RAMP_DOWN;
        end else if (Overflow_i) begin
          if (dwell_hit) begin
            cnt_d = '0;
            if (tw_q == stop_q || step_q == '0) begin
              state_d = RAMP_DOWN;
            end else begin
              tw_d = tw_step;
            end
          end else begin
            cnt_d = cnt_inc[DWELL_WIDTH-1:0];
          end
        end
      end
      RAMP_DOWN: begin
        amp_d = amp_dec;
        if (amp_dec == AMP_ZERO) begin
          state_d = DONE;
        end
      end
      DONE: begin
        amp_d   = AMP_ZERO;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RAMP_UP) || (state_d == SWEEP) || (state_d == RAMP_DOWN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      tw_q    <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      up_q    <= 1'b0;
      amp_q   <= '0;
      ramp_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tw_q    <= tw_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      up_q    <= up_d;
      amp_q   <= amp_d;
      ramp_q  <= ramp_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TuningWord_o = tw_q;
  assign Amplitude_o  = amp_q;
  assign Busy_o       = busy_q;
  assign Done_o       = done_q;

endmodule
`default_nettype wire
